clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
//
// Purpose
//   Programmable integer clock divider with a ratio-change handshake.
//   It produces a divided clock `f` at ck/N and a one-cycle `tick` on the last
//   ck cycle of every period. A new ratio is applied only on a period boundary,
//   so `f` never shows a truncated or stretched period.
//
// Parameters
//   W        width of the ratio field and the period counter
//   RST_DIV  ratio loaded by reset (legal range 2 .. 2**W-1)
//
// Ports
//   ck         in   sole clock
//   rs_n       in   asynchronous active-low reset
//   en         in   run request; dropping it stops at the end of the period
//   div_req    in   ratio-change request, held until div_ack (or div_err)
//   div_val    in   requested ratio N, stable while div_req is high
//   div_ack    out  one-cycle pulse: new ratio loaded
//   div_err    out  one-cycle pulse: request rejected (div_val < 2)
//   busy       out  request accepted, waiting for the period boundary
//   f          out  divided clock
//   tick       out  one-cycle pulse when cnt == N-1
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 PEND, 3 STOP)
//
// Handshake
//   div_req/div_val form a request that the requester holds until it sees
//   div_ack or div_err. A valid request (div_val >= 2) is loaded at the edge
//   where the counter is at N-1 (or at once when IDLE); div_ack follows one
//   cycle later. While div_ack or div_err is high the held request is ignored,
//   which gives the requester one cycle to drop div_req without a repeat load
//   or a second error pulse.
//
// Configuration
//   CLKDIV_ODD50_EN  when defined, a negedge flop stretches the high phase of
//                    odd ratios by half a ck period to get 50% duty. When
//                    undefined, odd ratios are high for (N-1)/2 of N cycles.
//                    Even ratios behave identically in both builds.
// -----------------------------------------------------------------------------
module clkdiv_ctrl #(
  parameter int W       = 4,
  parameter int RST_DIV = 3
) (
  input  logic         ck,
  input  logic         rs_n,
  input  logic         en,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         busy,
  output logic         f,
  output logic         tick,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [W-1:0] RST_N   = W'(RST_DIV);
  localparam logic [W-1:0] MIN_DIV = W'(2);
  localparam logic [W-1:0] ONE     = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q,   cnt_d;
  logic [W-1:0] n_q,     n_d;
  logic         ack_q,   ack_d;
  logic         err_q,   err_d;
  logic         f_pos_q, f_pos_d;

  logic         wrap;
  logic         req_ok;
  logic         req_bad;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  // The pulse cycle of ack/err masks the still-held request (see header).
  assign req_ok  = div_req && !ack_q && (div_val >= MIN_DIV);
  assign req_bad = div_req && !ack_q && !err_q && (div_val < MIN_DIV);

  // Last cycle of the current period.
  assign wrap = (cnt_q == (n_q - ONE));

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ack_d   = 1'b0;
    err_d   = req_bad;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Nothing is running, so a valid ratio can be taken immediately.
        if (req_ok) begin
          n_d   = div_val;
          ack_d = 1'b1;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (wrap) begin
          cnt_d = '0;
          // Request arriving exactly on the boundary: load without PEND.
          if (req_ok) begin
            n_d   = div_val;
            ack_d = 1'b1;
          end
          if (!en) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (req_ok) begin
            state_d = ST_PEND;
          end else if (!en) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_PEND: begin
        if (wrap) begin
          cnt_d = '0;
          if (req_ok) begin
            n_d   = div_val;
            ack_d = 1'b1;
          end
          // A stop requested while waiting takes effect after the load.
          state_d = en ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      ST_STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (req_ok) begin
            n_d   = div_val;
            ack_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // High phase is the first floor(N/2) counts, computed from next-state
    // values so the flop output always matches the current cnt_q / n_q.
    f_pos_d = (state_d != ST_IDLE) && (cnt_d < (n_d >> 1));
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= RST_N;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      f_pos_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      f_pos_q <= f_pos_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Divided clock output
  // ---------------------------------------------------------------------------
`ifdef CLKDIV_ODD50_EN
  logic f_neg_q;

  // Half-cycle delayed copy of f_pos. ORed in only for odd ratios, it extends
  // the high phase by half a ck period. It is always low at a period boundary
  // (f_pos is low on the last count for every N >= 2), so a ratio change
  // cannot glitch the output through the n_q[0] select.
  always_ff @(negedge ck or negedge rs_n) begin
    if (!rs_n) begin
      f_neg_q <= 1'b0;
    end else begin
      f_neg_q <= f_pos_q;
    end
  end

  assign f = f_pos_q | (f_neg_q & n_q[0]);
`else
  assign f = f_pos_q;
`endif

  // ---------------------------------------------------------------------------
  // Status outputs (all decoded from registers)
  // ---------------------------------------------------------------------------
  assign div_ack   = ack_q;
  assign div_err   = err_q;
  assign busy      = (state_q == ST_PEND);
  assign tick      = (state_q != ST_IDLE) && wrap;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  // Load and reject are mutually exclusive by construction of req_ok/req_bad.
  a_ack_err_excl: assert property (@(posedge ck) disable iff (!rs_n)
    !(div_ack && div_err));

  // The counter never leaves the 0 .. N-1 window.
  a_cnt_in_range: assert property (@(posedge ck) disable iff (!rs_n)
    cnt_q < n_q);
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_ctrl
//
// Directed bench for clkdiv_ctrl (W=4, RST_DIV=3). Inputs are driven 1 time
// unit after a rising edge; outputs are observed 1 time unit after the rising
// edge and, for duty measurement, 1 time unit after the falling edge.
// Expected high half-cycles per period: 2*floor(N/2), plus one for odd N when
// CLKDIV_ODD50_EN is defined.
// -----------------------------------------------------------------------------
module tb_clkdiv_ctrl;

  localparam int W = 4;

`ifdef CLKDIV_ODD50_EN
  localparam int ODD_EXTRA = 1;
`else
  localparam int ODD_EXTRA = 0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         ck = 1'b0;
  logic         rs_n = 1'b1;
  logic         en = 1'b0;
  logic         div_req = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_ack;
  logic         div_err;
  logic         busy;
  logic         f;
  logic         tick;
  logic [1:0]   dbg_state;

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  clkdiv_ctrl #(.W(W), .RST_DIV(3)) dut (
    .ck        (ck),
    .rs_n      (rs_n),
    .en        (en),
    .div_req   (div_req),
    .div_val   (div_val),
    .div_ack   (div_ack),
    .div_err   (div_err),
    .busy      (busy),
    .f         (f),
    .tick      (tick),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  // Called at posedge+1 of the first cycle of a period; ends at negedge+1 of
  // its last cycle. Counts high half-cycles of f and tick pulses.
  task automatic measure(input int n, output int hi, output int tk, output int last_tk);
    hi = 0; tk = 0; last_tk = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc();
      hi += int'(f);
      tk += int'(tick);
      last_tk = int'(tick);
      #5;
      hi += int'(f);
    end
  endtask

  function automatic int exp_hi(input int n);
    return 2 * (n / 2) + (((n % 2) == 1) ? ODD_EXTRA : 0);
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rs_n = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if (f !== 1'b0)          begin errors++; $display("FAIL rst_f got %0b want 0", f); end
    checks++; if (tick !== 1'b0)       begin errors++; $display("FAIL rst_tick got %0b want 0", tick); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (div_ack !== 1'b0)    begin errors++; $display("FAIL rst_ack got %0b want 0", div_ack); end
    checks++; if (div_err !== 1'b0)    begin errors++; $display("FAIL rst_err got %0b want 0", div_err); end
    cyc(); cyc();
    rs_n = 1'b1;
    cyc(); cyc();
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL idle_hold got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if (f !== 1'b0)          begin errors++; $display("FAIL idle_f got %0b want 0", f); end
  endtask

  task automatic test_run_n3();
    int hi, tk, lt;
    en = 1'b1;
    cyc();
    checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL run_entry got %0d want %0d", dbg_state, S_RUN); end
    for (int p = 0; p < 2; p++) begin
      if (p > 0) cyc();
      measure(3, hi, tk, lt);
      checks++; if (hi !== exp_hi(3)) begin errors++; $display("FAIL n3_high p%0d got %0d want %0d", p, hi, exp_hi(3)); end
      checks++; if (tk !== 1)          begin errors++; $display("FAIL n3_ticks p%0d got %0d want 1", p, tk); end
      checks++; if (lt !== 1)          begin errors++; $display("FAIL n3_tick_last p%0d got %0d want 1", p, lt); end
    end
  endtask

  task automatic test_ratio_change();
    int hi, tk, lt;
    cyc();                              // cnt=0, N=3
    div_req = 1'b1; div_val = 4'd4;
    cyc();                              // cnt=1, PEND
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL pend_busy1 got %0b want 1", busy); end
    cyc();                              // cnt=2, PEND
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL pend_busy2 got %0b want 1", busy); end
    checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL pend_early_ack got %0b want 0", div_ack); end
    cyc();                              // loaded, cnt=0, N=4
    checks++; if (div_ack !== 1'b1) begin errors++; $display("FAIL load_ack got %0b want 1", div_ack); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL load_busy got %0b want 0", busy); end
    checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL load_state got %0d want %0d", dbg_state, S_RUN); end
    div_req = 1'b0;
    cyc();                              // cnt=1
    checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse_len got %0b want 0", div_ack); end
    cyc(); cyc(); cyc();                // cnt=0
    measure(4, hi, tk, lt);
    checks++; if (hi !== exp_hi(4)) begin errors++; $display("FAIL n4_high got %0d want %0d", hi, exp_hi(4)); end
    checks++; if (tk !== 1 || lt !== 1) begin errors++; $display("FAIL n4_tick got %0d/%0d want 1/1", tk, lt); end
  endtask

  task automatic test_reject();
    int hi, tk, lt;
    cyc();                              // cnt=0, N=4
    div_req = 1'b1; div_val = 4'd1;
    cyc();
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL rej_err got %0b want 1", div_err); end
    checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL rej_ack got %0b want 0", div_ack); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rej_busy got %0b want 0", busy); end
    div_req = 1'b0;
    cyc();
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL rej_err_len got %0b want 0", div_err); end
    cyc(); cyc();                       // cnt=0
    measure(4, hi, tk, lt);
    checks++; if (hi !== exp_hi(4) || tk !== 1 || lt !== 1) begin
      errors++; $display("FAIL rej_period got hi=%0d tk=%0d want hi=%0d tk=1", hi, tk, exp_hi(4));
    end
  endtask

  task automatic test_wrap_load_and_stop();
    int hi, tk, lt;
    // Now at negedge of the cnt=3 cycle: request lands exactly on the boundary.
    div_req = 1'b1; div_val = 4'd5;
    cyc();
    checks++; if (div_ack !== 1'b1) begin errors++; $display("FAIL wrap_ack got %0b want 1", div_ack); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL wrap_busy got %0b want 0", busy); end
    div_req = 1'b0;
    measure(5, hi, tk, lt);
    checks++; if (hi !== exp_hi(5)) begin errors++; $display("FAIL n5_high got %0d want %0d", hi, exp_hi(5)); end
    checks++; if (tk !== 1 || lt !== 1) begin errors++; $display("FAIL n5_tick got %0d/%0d want 1/1", tk, lt); end
    cyc(); cyc();                       // cnt=1
    en = 1'b0;
    cyc();                              // cnt=2
    checks++; if (dbg_state !== S_STOP) begin errors++; $display("FAIL stop_state got %0d want %0d", dbg_state, S_STOP); end
    cyc(); cyc();                       // cnt=4
    checks++; if (tick !== 1'b1)    begin errors++; $display("FAIL stop_tick got %0b want 1", tick); end
    cyc();
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL stop_idle got %0d want %0d", dbg_state, S_IDLE); end
    measure(4, hi, tk, lt);
    checks++; if (hi !== 0 || tk !== 0) begin errors++; $display("FAIL stop_quiet got hi=%0d tk=%0d want 0/0", hi, tk); end
  endtask

  task automatic test_wrap_en_low_with_req();
    int hi, tk, lt;
    en = 1'b1;
    cyc();                              // RUN cnt=0, N=5
    cyc(); cyc(); cyc(); cyc();         // cnt=4
    en = 1'b0; div_req = 1'b1; div_val = 4'd3;
    cyc();
    checks++; if (div_ack !== 1'b1)     begin errors++; $display("FAIL enlow_ack got %0b want 1", div_ack); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL enlow_idle got %0d want %0d", dbg_state, S_IDLE); end
    div_req = 1'b0;
    cyc();
    checks++; if (div_ack !== 1'b0)     begin errors++; $display("FAIL enlow_ack_len got %0b want 0", div_ack); end
    en = 1'b1;
    cyc();
    measure(3, hi, tk, lt);
    checks++; if (hi !== exp_hi(3) || tk !== 1 || lt !== 1) begin
      errors++; $display("FAIL enlow_n3 got hi=%0d tk=%0d want hi=%0d tk=1", hi, tk, exp_hi(3));
    end
  endtask

  task automatic test_pend_en_low();
    cyc();                              // cnt=0, N=3
    div_req = 1'b1; div_val = 4'd4;
    cyc();                              // PEND cnt=1
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL pstop_busy got %0b want 1", busy); end
    en = 1'b0;
    cyc();                              // cnt=2, still PEND
    checks++; if (dbg_state !== S_PEND) begin errors++; $display("FAIL pstop_pend got %0d want %0d", dbg_state, S_PEND); end
    cyc();
    checks++; if (div_ack !== 1'b1)     begin errors++; $display("FAIL pstop_ack got %0b want 1", div_ack); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL pstop_idle got %0d want %0d", dbg_state, S_IDLE); end
    div_req = 1'b0;
  endtask

  task automatic test_reset_mid_pend();
    int hi, tk, lt;
    int acks;
    en = 1'b1;
    cyc();                              // RUN cnt=0, N=4
    div_req = 1'b1; div_val = 4'd6;
    cyc(); cyc();                       // PEND cnt=2
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL rpend_busy got %0b want 1", busy); end
    #2 rs_n = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || busy !== 1'b0 || f !== 1'b0 || tick !== 1'b0 || div_ack !== 1'b0) begin
      errors++; $display("FAIL rpend_async got st=%0d busy=%0b f=%0b tick=%0b ack=%0b want 0", dbg_state, busy, f, tick, div_ack);
    end
    div_req = 1'b0; en = 1'b0;
    #2 rs_n = 1'b1;
    acks = 0;
    cyc();
    acks += int'(div_ack);
    en = 1'b1;
    cyc();
    acks += int'(div_ack);
    measure(3, hi, tk, lt);
    acks += int'(div_ack);
    checks++; if (acks !== 0) begin errors++; $display("FAIL rpend_no_ack got %0d want 0", acks); end
    checks++; if (hi !== exp_hi(3) || tk !== 1 || lt !== 1) begin
      errors++; $display("FAIL rpend_n3 got hi=%0d tk=%0d want hi=%0d tk=1", hi, tk, exp_hi(3));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_run_n3();
    test_ratio_change();
    test_reject();
    test_wrap_load_and_stop();
    test_wrap_en_low_with_req();
    test_pend_en_low();
    test_reset_mid_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
